// File: rtl/ft245_rx_word_packer.sv
// Packs the FT245 receive byte stream into big-endian 32-bit words, one write strobe each.
// Partial words leave early on a new frame, an explicit flush or an idle timeout.
module ft245_rx_word_packer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        ftdi_clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_sof,
    output logic        byte_ready,
    input  logic        flush,
    input  logic        word_full,
    output logic        word_wr,
    output logic [31:0] word_data,
    output logic        word_sof,
    output logic [2:0]  word_bytes,
    output logic [15:0] frame_count
);
    // Handshakes: a byte transfers when byte_valid & byte_ready; a word transfers
    // when word_wr is high, which only happens while word_full is low.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] acc, acc_next;
    logic [1:0]  count, count_next;
    logic        acc_sof, acc_sof_next;
    logic [15:0] idle_cnt, idle_cnt_next;
    logic        flush_pend, flush_pend_next;
    logic        ready_q;
    logic        pending, pending_next;
    logic        accept, flush_req, timeout_hit, move;
    logic [31:0] move_data;
    logic        move_sof;
    logic [2:0]  move_bytes;
    logic [1:0]  lane;
    logic [31:0] acc_ins;

    assign byte_ready = ready_q;

    always_comb begin
        accept        = byte_valid & ready_q;
        pending       = (state == HOLD);
        lane          = 2'd3 - count;
        acc_ins       = acc | ({24'h0, byte_data} << {lane, 3'b000});
        acc_next      = acc;
        count_next    = count;
        acc_sof_next  = acc_sof;
        move          = 1'b0;
        move_data     = acc;
        move_sof      = acc_sof;
        move_bytes    = {1'b0, count};

        if (accept) begin
            if (byte_sof && count != 2'd0) begin
                // Old partial leaves; the SOF byte opens the new word on the same edge.
                move         = 1'b1;
                acc_next     = {byte_data, 24'h0};
                count_next   = 2'd1;
                acc_sof_next = 1'b1;
            end else if (count == 2'd3) begin
                move         = 1'b1;
                move_data    = acc_ins;
                move_sof     = acc_sof | byte_sof;
                move_bytes   = 3'd4;
                acc_next     = 32'h0;
                count_next   = 2'd0;
                acc_sof_next = 1'b0;
            end else begin
                acc_next     = acc_ins;
                count_next   = count + 2'd1;
                acc_sof_next = acc_sof | byte_sof;
            end
        end

        timeout_hit     = (count != 2'd0) && !accept &&
                          (idle_cnt >= 16'(TIMEOUT_CYCLES - 1));
        flush_req       = flush | flush_pend | timeout_hit;
        flush_pend_next = 1'b0;
        // A flush that cannot move now (output busy) is remembered until it can.
        if (flush_req && count_next != 2'd0) begin
            if (move || pending) begin
                flush_pend_next = 1'b1;
            end else begin
                move         = 1'b1;
                move_data    = acc_next;
                move_sof     = acc_sof_next;
                move_bytes   = {1'b0, count_next};
                acc_next     = 32'h0;
                count_next   = 2'd0;
                acc_sof_next = 1'b0;
            end
        end

        word_wr      = pending & !word_full;
        pending_next = move | (pending & word_full);

        if (accept || move || count == 2'd0)
            idle_cnt_next = 16'h0;
        else if (idle_cnt == 16'hFFFF)
            idle_cnt_next = idle_cnt;
        else
            idle_cnt_next = idle_cnt + 16'd1;

        case (state)
            IDLE, COLLECT, HOLD: begin
                if (pending_next)
                    state_next = HOLD;
                else if (count_next != 2'd0)
                    state_next = COLLECT;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= 32'h0;
            count       <= 2'd0;
            acc_sof     <= 1'b0;
            idle_cnt    <= 16'h0;
            flush_pend  <= 1'b0;
            ready_q     <= 1'b0;
            word_data   <= 32'h0;
            word_sof    <= 1'b0;
            word_bytes  <= 3'd0;
            frame_count <= 16'h0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            count      <= count_next;
            acc_sof    <= acc_sof_next;
            idle_cnt   <= idle_cnt_next;
            flush_pend <= flush_pend_next;
            ready_q    <= !pending_next;
            if (move) begin
                word_data  <= move_data;
                word_sof   <= move_sof;
                word_bytes <= move_bytes;
            end
            if (accept && byte_sof)
                frame_count <= frame_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_ft245_rx_word_packer.sv
// Bench for ft245_rx_word_packer: cycle table, hand-written corner sequences,
// then random traffic checked against a byte-queue packing model.
`timescale 1ns/1ps
module tb_ft245_rx_word_packer;
    localparam int unsigned TO = 256;
    localparam int W = 36;

    logic        ftdi_clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h0;
    logic        byte_sof = 1'b0;
    logic        flush = 1'b0;
    logic        word_full = 1'b0;
    logic        byte_ready, word_wr, word_sof;
    logic [31:0] word_data;
    logic [2:0]  word_bytes;
    logic [15:0] frame_count;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   part[$];
    logic         part_sof = 1'b0;
    int           m_frames = 0;
    logic         mon_on = 1'b0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        s;
        logic        f;
        logic        exp_wr;
        logic        exp_rdy;
        logic [31:0] exp_data;
        logic        exp_sof;
        logic [2:0]  exp_bytes;
    } vec_t;
    vec_t tbl[24];

    ft245_rx_word_packer #(.TIMEOUT_CYCLES(TO)) dut (
        .ftdi_clk(ftdi_clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_sof(byte_sof), .byte_ready(byte_ready), .flush(flush), .word_full(word_full),
        .word_wr(word_wr), .word_data(word_data), .word_sof(word_sof),
        .word_bytes(word_bytes), .frame_count(frame_count)
    );

    always #5 ftdi_clk = ~ftdi_clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_word(input logic [7:0] b[$], input logic s);
        logic [31:0] d;
        d = 32'h0;
        for (int i = 0; i < b.size(); i++) d[31-8*i -: 8] = b[i];
        return {s, 3'(b.size()), d};
    endfunction

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic s, input logic f,
                                input logic wr, input logic rdy, input logic [31:0] ed,
                                input logic es, input logic [2:0] eb);
        vec_t r;
        r.v = v; r.d = d; r.s = s; r.f = f;
        r.exp_wr = wr; r.exp_rdy = rdy; r.exp_data = ed; r.exp_sof = es; r.exp_bytes = eb;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic f);
        @(posedge ftdi_clk); #1;
        byte_valid = v; byte_data = d; byte_sof = s; flush = f;
    endtask

    // Scoreboard: packs the accepted byte stream by the framing rules and checks each written word.
    always @(negedge ftdi_clk) begin
        if (mon_on) begin
            if (word_wr) begin
                chk("rnd_wr_while_full", {35'h0, word_full}, '0);
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_word", {word_sof, word_bytes, word_data}, '0);
                end else begin
                    chk("rnd_word", {word_sof, word_bytes, word_data}, exp_q.pop_front());
                end
            end
            if (byte_valid && byte_ready) begin
                if (byte_sof) begin
                    m_frames++;
                    if (part.size() > 0) begin
                        exp_q.push_back(pack_word(part, part_sof));
                        part.delete();
                    end
                    part_sof = 1'b1;
                end
                part.push_back(byte_data);
                if (part.size() == 4) begin
                    exp_q.push_back(pack_word(part, part_sof));
                    part.delete();
                    part_sof = 1'b0;
                end
            end
            if (flush && part.size() > 0) begin
                exp_q.push_back(pack_word(part, part_sof));
                part.delete();
                part_sof = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hit_k;
        int n;
        int v_rdy, v_wr, v_data;
        logic [W-1:0] got;

        tbl[0]  = mk(1, 8'h01, 1, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[1]  = mk(1, 8'h02, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[2]  = mk(1, 8'h03, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[3]  = mk(1, 8'h04, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[4]  = mk(0, 8'h00, 0, 0, 1, 0, 32'h01020304, 1, 3'd4);
        tbl[5]  = mk(1, 8'h05, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[6]  = mk(1, 8'h06, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[7]  = mk(1, 8'h07, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[8]  = mk(1, 8'h08, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[9]  = mk(0, 8'h00, 0, 0, 1, 0, 32'h05060708, 0, 3'd4);
        tbl[10] = mk(1, 8'hAA, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[11] = mk(1, 8'hBB, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[12] = mk(1, 8'hCC, 1, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[13] = mk(0, 8'h00, 0, 0, 1, 0, 32'hAABB0000, 0, 3'd2);
        tbl[14] = mk(1, 8'hDD, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[15] = mk(1, 8'hEE, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[16] = mk(1, 8'hFF, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[17] = mk(0, 8'h00, 0, 0, 1, 0, 32'hCCDDEEFF, 1, 3'd4);
        tbl[18] = mk(0, 8'h00, 0, 1, 0, 1, 32'h0, 0, 3'd0);
        tbl[19] = mk(0, 8'h00, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[20] = mk(1, 8'h99, 0, 0, 0, 1, 32'h0, 0, 3'd0);
        tbl[21] = mk(1, 8'h9A, 0, 1, 0, 1, 32'h0, 0, 3'd0);
        tbl[22] = mk(0, 8'h00, 0, 0, 1, 0, 32'h999A0000, 0, 3'd2);
        tbl[23] = mk(0, 8'h00, 0, 0, 0, 1, 32'h0, 0, 3'd0);

        // Reset state
        repeat (3) @(posedge ftdi_clk);
        @(negedge ftdi_clk);
        chk("rst_ready", {35'h0, byte_ready}, '0);
        chk("rst_wr", {35'h0, word_wr}, '0);
        chk("rst_word", {word_sof, word_bytes, word_data}, '0);
        chk("rst_frames", {20'h0, frame_count}, '0);
        @(posedge ftdi_clk); #1 rst = 1'b0;
        @(posedge ftdi_clk);
        @(negedge ftdi_clk);
        chk("post_rst_ready", {35'h0, byte_ready}, 36'd1);

        // Cycle table
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].f);
            @(negedge ftdi_clk);
            chk($sformatf("row%0d_ready", i), {35'h0, byte_ready}, {35'h0, tbl[i].exp_rdy});
            chk($sformatf("row%0d_wr", i), {35'h0, word_wr}, {35'h0, tbl[i].exp_wr});
            if (tbl[i].exp_wr)
                chk($sformatf("row%0d_word", i), {word_sof, word_bytes, word_data},
                    {tbl[i].exp_sof, tbl[i].exp_bytes, tbl[i].exp_data});
        end
        chk("table_frames", {20'h0, frame_count}, 36'd2);

        // Idle timeout flushes a 3-byte tail
        drive(1, 8'h11, 0, 0);
        drive(1, 8'h22, 0, 0);
        drive(1, 8'h33, 0, 0);
        hit_k = 0;
        got = '0;
        for (int k = 1; k <= TO + 10 && hit_k == 0; k++) begin
            drive(0, 8'h00, 0, 0);
            @(negedge ftdi_clk);
            if (word_wr) begin
                hit_k = k;
                got = {word_sof, word_bytes, word_data};
            end
        end
        chk("timeout_cycle", W'(hit_k), W'(TO + 1));
        chk("timeout_word", got, {1'b0, 3'd3, 32'h11223300});
        n = 0;
        for (int k = 0; k < 300; k++) begin
            drive(0, 8'h00, 0, 0);
            @(negedge ftdi_clk);
            if (word_wr) n++;
        end
        chk("idle_empty_no_wr", W'(n), '0);

        // Downstream full holds the word and stalls input
        drive(1, 8'h41, 0, 0);
        word_full = 1'b1;
        drive(1, 8'h42, 0, 0);
        drive(1, 8'h43, 0, 0);
        drive(1, 8'h44, 0, 0);
        v_rdy = 0; v_wr = 0; v_data = 0;
        for (int k = 0; k < 50; k++) begin
            drive(1, 8'h55, 0, 0);
            @(negedge ftdi_clk);
            if (byte_ready !== 1'b0) v_rdy++;
            if (word_wr !== 1'b0) v_wr++;
            if (word_data !== 32'h41424344) v_data++;
        end
        chk("full_ready_low", W'(v_rdy), '0);
        chk("full_no_wr", W'(v_wr), '0);
        chk("full_out_stable", W'(v_data), '0);
        @(posedge ftdi_clk); #1 word_full = 1'b0;
        @(negedge ftdi_clk);
        chk("release_wr", {35'h0, word_wr}, 36'd1);
        chk("release_word", {word_sof, word_bytes, word_data}, {1'b0, 3'd4, 32'h41424344});
        @(posedge ftdi_clk);
        @(negedge ftdi_clk);
        chk("release_single_wr", {35'h0, word_wr}, '0);
        chk("release_ready", {35'h0, byte_ready}, 36'd1);
        drive(0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 0);
        @(negedge ftdi_clk);
        chk("held_byte_wr", {35'h0, word_wr}, 36'd1);
        chk("held_byte_word", {word_sof, word_bytes, word_data}, {1'b0, 3'd1, 32'h55000000});

        // Reset mid-word drops the partial
        drive(1, 8'h77, 1, 0);
        drive(1, 8'h88, 0, 0);
        @(posedge ftdi_clk); #1;
        rst = 1'b1; byte_valid = 1'b0; byte_sof = 1'b0;
        @(posedge ftdi_clk);
        @(negedge ftdi_clk);
        chk("midrst_wr", {35'h0, word_wr}, '0);
        chk("midrst_word", {word_sof, word_bytes, word_data}, '0);
        chk("midrst_frames", {20'h0, frame_count}, '0);
        chk("midrst_ready", {35'h0, byte_ready}, '0);
        @(posedge ftdi_clk); #1 rst = 1'b0;
        @(posedge ftdi_clk);
        drive(1, 8'hA1, 1, 0);
        drive(1, 8'hA2, 0, 0);
        drive(1, 8'hA3, 0, 0);
        drive(1, 8'hA4, 0, 0);
        n = 0;
        got = '0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 8'h00, 0, 0);
            @(negedge ftdi_clk);
            if (word_wr) begin
                n++;
                got = {word_sof, word_bytes, word_data};
            end
        end
        chk("postrst_word_count", W'(n), 36'd1);
        chk("postrst_word", got, {1'b1, 3'd4, 32'hA1A2A3A4});
        chk("postrst_frames", {20'h0, frame_count}, 36'd1);

        // Random traffic against the scoreboard
        @(posedge ftdi_clk); #1 rst = 1'b1;
        @(posedge ftdi_clk); #1 rst = 1'b0;
        @(posedge ftdi_clk);
        exp_q.delete();
        part.delete();
        part_sof = 1'b0;
        m_frames = 0;
        mon_on = 1'b1;
        for (int k = 0; k < 800; k++) begin
            @(posedge ftdi_clk); #1;
            byte_valid = ($urandom_range(0, 9) < 7);
            byte_data  = 8'($urandom);
            byte_sof   = ($urandom_range(0, 9) == 0);
            word_full  = ($urandom_range(0, 9) < 3);
            flush      = 1'b0;
        end
        @(posedge ftdi_clk); #1;
        byte_valid = 1'b0; byte_sof = 1'b0; word_full = 1'b0;
        repeat (3) @(posedge ftdi_clk);
        drive(0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 0);
        repeat (10) @(posedge ftdi_clk);
        @(negedge ftdi_clk);
        mon_on = 1'b0;
        chk("rnd_queue_drained", W'(exp_q.size()), '0);
        chk("rnd_frames", {20'h0, frame_count}, W'(m_frames));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
